pebble_core_mc: RTL and testbench

PEBBLE_CORE_MC -- requirements
Module: pebble_core_mc

---
 rtl/pebble_pkg.sv | 48 ++++
 rtl/pebble_alu.sv | 28 ++
 rtl/pebble_core_mc.sv | 157 +++++++++++++++
 tb/tb_pebble_core_mc.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pebble_pkg.sv
// Shared types and instruction field positions for the pebble multi-cycle core.
package pebble_pkg;

  typedef enum logic [1:0] {
    R = 2'b00,
    I = 2'b01,
    M = 2'b10,
    B = 2'b11
  } instr_type_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL1 = 3'd5,
    ALU_SHR1 = 3'd6,
    ALU_NOT  = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam int F_TYPE_HI = 8, F_TYPE_LO = 7;
  localparam int F_FUNC_HI = 6, F_FUNC_LO = 4;
  localparam int F_RS1_HI  = 3, F_RS1_LO  = 2;
  localparam int F_RS2_HI  = 1, F_RS2_LO  = 0;
  localparam int F_IRD_HI  = 6, F_IRD_LO  = 5;
  localparam int F_IMM_HI  = 4, F_IMM_LO  = 0;
  localparam int F_L_BIT   = 6;
  localparam int F_RT_HI   = 5, F_RT_LO   = 4;
  localparam int F_MADR_HI = 3, F_MADR_LO = 0;
  localparam int F_HALT    = 6;
  localparam int F_TGT_HI  = 5, F_TGT_LO  = 4;
  localparam int F_BA_HI   = 3, F_BA_LO   = 2;
  localparam int F_BB_HI   = 1, F_BB_LO   = 0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pebble_alu.sv
// Pebble ALU: combinational datapath for the eight R-type functions.
module pebble_alu
  import pebble_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [2:0]    i_op,
  output logic [DW-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (alu_op_e'(i_op))
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SHL1: o_y = {i_a[DW-2:0], 1'b0};
      ALU_SHR1: o_y = {1'b0, i_a[DW-1:1]};
      ALU_NOT:  o_y = ~i_a;
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/pebble_core_mc.sv
// Pebble multi-cycle core: fetch/exec/mem sequencer with a four-entry register file.
// state    | meaning
// IDLE     | one settling cycle after reset
// FETCH    | imem request outstanding
// EXEC     | decode and execute latched instruction
// MEM      | dmem request outstanding
// HALT     | stopped until reset
module pebble_core_mc
  import pebble_pkg::*;
#(
  parameter int DW  = 8,
  parameter int PCW = 10,
  parameter int IW  = 9
) (
  input  logic           Clk,
  input  logic           Reset,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_valid,
  input  logic [IW-1:0]  imem_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_valid,
  input  logic [DW-1:0]  dmem_rdata,
  output logic           Done,
  output logic [31:0]    retired
);

  if (IW != 9) begin : g_iw_check
    $error("pebble_core_mc: IW must be 9");
  end
  if (DW < 8 || DW > 32) begin : g_dw_check
    $error("pebble_core_mc: DW must be in 8..32");
  end

  state_e         r_state;
  logic [PCW-1:0] r_pc;
  logic [DW-1:0]  r_reg [4];
  logic [IW-1:0]  r_ir;
  logic [31:0]    r_retired;

  instr_type_e    w_type;
  logic [2:0]     w_func;
  logic [1:0]     w_rs1;
  logic [1:0]     w_rs2;
  logic [1:0]     w_ird;
  logic [4:0]     w_imm;
  logic           w_load;
  logic [1:0]     w_rt;
  logic [3:0]     w_maddr;
  logic           w_halt;
  logic [1:0]     w_tgt;
  logic [1:0]     w_ba;
  logic [1:0]     w_bb;
  logic [DW-1:0]  w_alu_y;
  logic [DW-1:0]  w_imm_ext;
  logic [PCW-1:0] w_pc_inc;
  logic [PCW-1:0] w_br_tgt;
  logic           w_br_taken;

  assign w_type  = instr_type_e'(r_ir[F_TYPE_HI:F_TYPE_LO]);
  assign w_func  = r_ir[F_FUNC_HI:F_FUNC_LO];
  assign w_rs1   = r_ir[F_RS1_HI:F_RS1_LO];
  assign w_rs2   = r_ir[F_RS2_HI:F_RS2_LO];
  assign w_ird   = r_ir[F_IRD_HI:F_IRD_LO];
  assign w_imm   = r_ir[F_IMM_HI:F_IMM_LO];
  assign w_load  = r_ir[F_L_BIT];
  assign w_rt    = r_ir[F_RT_HI:F_RT_LO];
  assign w_maddr = r_ir[F_MADR_HI:F_MADR_LO];
  assign w_halt  = r_ir[F_HALT];
  assign w_tgt   = r_ir[F_TGT_HI:F_TGT_LO];
  assign w_ba    = r_ir[F_BA_HI:F_BA_LO];
  assign w_bb    = r_ir[F_BB_HI:F_BB_LO];

  assign w_imm_ext  = {{(DW-5){1'b0}}, w_imm};
  assign w_pc_inc   = r_pc + PCW'(1);
  // Branch target register is zero-extended or truncated to the PC width.
  assign w_br_tgt   = PCW'(r_reg[w_tgt]);
  assign w_br_taken = (r_reg[w_ba] == r_reg[w_bb]);

  pebble_alu #(.DW(DW)) u_alu (
    .i_a  (r_reg[w_rs1]),
    .i_b  (r_reg[w_rs2]),
    .i_op (w_func),
    .o_y  (w_alu_y)
  );

  // Requests are gated by Reset so an in-flight access drops immediately.
  assign imem_req   = (r_state == ST_FETCH) && !Reset;
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == ST_MEM) && !Reset;
  assign dmem_we    = ~w_load;
  assign dmem_addr  = {{(DW-4){1'b0}}, w_maddr};
  assign dmem_wdata = r_reg[w_rt];
  assign Done       = (r_state == ST_HALT);
  assign retired    = r_retired;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
      for (int k = 0; k < 4; k++) r_reg[k] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_valid) begin
            r_ir    <= imem_data;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (w_type)
            R: begin
              r_reg[w_rs1] <= w_alu_y;
              r_pc         <= w_pc_inc;
              r_retired    <= sat_inc32(r_retired);
              r_state      <= ST_FETCH;
            end
            I: begin
              r_reg[w_ird] <= w_imm_ext;
              r_pc         <= w_pc_inc;
              r_retired    <= sat_inc32(r_retired);
              r_state      <= ST_FETCH;
            end
            M: r_state <= ST_MEM;
            B: begin
              r_retired <= sat_inc32(r_retired);
              if (w_halt) begin
                r_state <= ST_HALT;
              end else begin
                r_pc    <= w_br_taken ? w_br_tgt : w_pc_inc;
                r_state <= ST_FETCH;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
        ST_MEM: begin
          if (dmem_valid) begin
            if (w_load) r_reg[w_rt] <= dmem_rdata;
            r_pc      <= w_pc_inc;
            r_retired <= sat_inc32(r_retired);
            r_state   <= ST_FETCH;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pebble_core_mc.sv
// Bench for pebble_core_mc: directed scenarios plus random programs against an ISA-level model.
module tb_pebble_core_mc;
  localparam int DW   = 8;
  localparam int PCW  = 10;
  localparam int IW   = 9;
  localparam int PCN  = 1 << PCW;
  localparam int MASK = (1 << DW) - 1;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_valid = 1'b0;
  logic [IW-1:0]  imem_data = '0;
  logic           dmem_req;
  logic           dmem_we;
  logic [DW-1:0]  dmem_addr;
  logic [DW-1:0]  dmem_wdata;
  logic           dmem_valid = 1'b0;
  logic [DW-1:0]  dmem_rdata = '0;
  logic           Done;
  logic [31:0]    retired;

  always #5 Clk = ~Clk;

  pebble_core_mc #(.DW(DW), .PCW(PCW), .IW(IW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_valid (dmem_valid),
    .dmem_rdata (dmem_rdata),
    .Done       (Done),
    .retired    (retired)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [IW-1:0] prog [PCN];
  int            m_pc;
  int            m_reg [4];
  int unsigned   m_ret;
  int            fdly = 0;
  int            ddly = 0;
  int            t_prev = 0;
  int            last_gap = 0;
  logic [DW-1:0] last_wdata = '0;
  logic [DW-1:0] last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc_r(int f, int rd, int rs2);
    return {2'b00, 3'(f), 2'(rd), 2'(rs2)};
  endfunction
  function automatic logic [IW-1:0] enc_i(int rd, int imm);
    return {2'b01, 2'(rd), 5'(imm)};
  endfunction
  function automatic logic [IW-1:0] enc_m(int l, int rt, int a);
    return {2'b10, 1'(l), 2'(rt), 4'(a)};
  endfunction
  function automatic logic [IW-1:0] enc_b(int h, int t, int a, int b);
    return {2'b11, 1'(h), 2'(t), 2'(a), 2'(b)};
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_ret = 0;
    for (int k = 0; k < 4; k++) m_reg[k] = 0;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_done", Done, 0);
    chk("rst_retired", retired, 0);
    chk("rst_pc", imem_addr, 0);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_fetch(output bit ok);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 64) begin
      @(negedge Clk);
      dmem_valid = 1'b0;
      n++;
    end
    ok = (imem_req === 1'b1);
    if (!ok) chk("fetch_timeout", 0, 1);
  endtask

  task automatic do_instr(input bit abort_mem);
    logic [IW-1:0] ins;
    logic [DW-1:0] rd_val;
    int d, n, a, b, y, rt;
    bit ok;
    wait_fetch(ok);
    if (!ok) return;
    last_gap = cyc - t_prev;
    t_prev = cyc;
    chk("imem_addr", imem_addr, m_pc);
    chk("retired", retired, m_ret);
    chk("done_low", Done, 0);
    d = (fdly >= 0) ? fdly : $urandom_range(0, 2);
    repeat (d) begin
      @(negedge Clk);
      dmem_valid = 1'b0;
      chk("fetch_hold", {imem_req, imem_addr}, {1'b1, PCW'(m_pc)});
    end
    ins = prog[m_pc];
    imem_valid = 1'b1;
    imem_data = ins;
    @(negedge Clk);
    imem_valid = 1'b0;
    imem_data = IW'($urandom);
    dmem_valid = (fdly < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    dmem_rdata = DW'($urandom);
    case (ins[8:7])
      2'b00: begin
        a = m_reg[ins[3:2]];
        b = m_reg[ins[1:0]];
        case (int'(ins[6:4]))
          0: y = a + b;
          1: y = a - b;
          2: y = a & b;
          3: y = a | b;
          4: y = a ^ b;
          5: y = a * 2;
          6: y = a / 2;
          default: y = MASK - a;
        endcase
        m_reg[ins[3:2]] = y & MASK;
        m_pc = (m_pc + 1) % PCN;
        m_ret++;
      end
      2'b01: begin
        m_reg[ins[6:5]] = int'(ins[4:0]);
        m_pc = (m_pc + 1) % PCN;
        m_ret++;
      end
      2'b10: begin
        rt = int'(ins[5:4]);
        n = 0;
        do begin
          @(negedge Clk);
          dmem_valid = 1'b0;
          n++;
        end while (dmem_req !== 1'b1 && n < 64);
        if (dmem_req !== 1'b1) begin
          chk("mem_timeout", 0, 1);
          return;
        end
        d = (ddly >= 0) ? ddly : $urandom_range(0, 3);
        for (int w = 0; w <= d; w++) begin
          if (w > 0) @(negedge Clk);
          chk("dmem_ctl", {dmem_req, dmem_we, dmem_addr}, {1'b1, ~ins[6], DW'(ins[3:0])});
          chk("imem_idle", imem_req, 0);
          if (!ins[6]) chk("dmem_wdata", dmem_wdata, m_reg[rt]);
          imem_valid = 1'($urandom_range(0, 1));
          imem_data = IW'($urandom);
        end
        if (abort_mem) begin
          Reset = 1'b1;
          dmem_valid = 1'b1;
          dmem_rdata = '1;
          #1;
          chk("rst_drop_dmem", dmem_req, 0);
          chk("rst_drop_imem", imem_req, 0);
          @(negedge Clk);
          dmem_valid = 1'b0;
          imem_valid = 1'b0;
          chk("rst_mem_done", Done, 0);
          chk("rst_mem_ret", retired, 0);
          Reset = 1'b0;
          model_reset();
          return;
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b1;
        rd_val = DW'($urandom);
        dmem_rdata = rd_val;
        last_wdata = dmem_wdata;
        last_addr = dmem_addr;
        @(negedge Clk);
        dmem_valid = 1'b0;
        if (ins[6]) m_reg[rt] = int'(rd_val);
        m_pc = (m_pc + 1) % PCN;
        m_ret++;
      end
      default: begin
        m_ret++;
        if (!ins[6]) begin
          if (m_reg[ins[3:2]] == m_reg[ins[1:0]]) m_pc = m_reg[ins[5:4]] % PCN;
          else m_pc = (m_pc + 1) % PCN;
        end
      end
    endcase
  endtask

  task automatic halt_check();
    repeat (12) begin
      @(negedge Clk);
      imem_valid = 1'($urandom_range(0, 1));
      dmem_valid = 1'($urandom_range(0, 1));
      imem_data = IW'($urandom);
      chk("halt_done", Done, 1);
      chk("halt_reqs", {imem_req, dmem_req}, 0);
      chk("halt_retired", retired, m_ret);
    end
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int k = 0; k < PCN; k++) prog[k] = enc_r(0, 0, 0);
    // directed program: arithmetic, stores, branches and halt
    prog[0]  = enc_i(1, 5);
    prog[1]  = enc_r(0, 1, 1);
    prog[2]  = enc_m(0, 1, 0);
    prog[3]  = enc_i(1, 20);
    prog[4]  = enc_r(5, 1, 0);
    prog[5]  = enc_r(5, 1, 0);
    prog[6]  = enc_r(5, 1, 0);
    prog[7]  = enc_i(2, 5);
    prog[8]  = enc_r(3, 1, 2);
    prog[9]  = enc_m(0, 1, 3);
    prog[10] = enc_i(2, 7);
    prog[11] = enc_i(3, 7);
    prog[12] = enc_i(0, 16);
    prog[13] = enc_r(5, 0, 0);
    prog[14] = enc_r(5, 0, 0);
    prog[15] = enc_b(0, 0, 2, 3);
    prog[16] = enc_r(0, 0, 0);
    prog[10'h40] = enc_i(3, 6);
    prog[10'h41] = enc_b(0, 0, 2, 3);
    prog[10'h42] = enc_m(1, 2, 5);
    prog[10'h43] = enc_b(1, 0, 0, 0);

    apply_reset();
    fdly = 0;
    ddly = 0;
    for (int k = 0; k < 16; k++) begin
      ddly = (k == 9) ? 4 : 0;
      do_instr(0);
      if (k == 1) begin
        chk("req037_gap", last_gap, 2);
        wait_fetch(ok);
        chk("req037_retired", retired, 2);
      end
      if (k == 2) chk("req037_r1", last_wdata, 10);
      if (k == 9) begin
        chk("req038_wdata", last_wdata, 8'hA5);
        chk("req038_addr", last_addr, 3);
        wait_fetch(ok);
        chk("req038_pc", imem_addr, 10);
      end
    end
    wait_fetch(ok);
    chk("req039_taken", imem_addr, 10'h40);
    do_instr(0);
    do_instr(0);
    wait_fetch(ok);
    chk("req039_not_taken", imem_addr, 10'h42);
    do_instr(0);
    do_instr(0);
    halt_check();

    // reset while a load is waiting
    apply_reset();
    prog[0] = enc_m(1, 1, 2);
    ddly = 2;
    do_instr(1);
    for (int k = 0; k < 4; k++) prog[k] = enc_m(0, k, k);
    ddly = 0;
    wait_fetch(ok);
    chk("req042_pc0", imem_addr, 0);
    for (int k = 0; k < 4; k++) begin
      do_instr(0);
      chk("req042_reg", last_wdata, 0);
    end

    // PC wrap through 2^PCW-1
    apply_reset();
    for (int k = 0; k < PCN; k++) prog[k] = enc_r(0, 0, 0);
    for (int k = 0; k < PCN; k++) do_instr(0);
    wait_fetch(ok);
    chk("req040_wrap", imem_addr, 0);

    // random programs with random handshake delays
    apply_reset();
    for (int k = 0; k < PCN; k++) begin
      prog[k] = IW'($urandom);
      if (prog[k][8:7] == 2'b11) prog[k][6] = 1'b0;
    end
    fdly = -1;
    ddly = -1;
    for (int k = 0; k < 300; k++) do_instr(0);
    prog[m_pc] = enc_b(1, 0, 0, 0);
    do_instr(0);
    halt_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
